// File: rtl/rr_otfc.sv
// Serial on-the-fly converter: MSD-first radix-R signed digits to a K-bit two's complement word.
// Optional illegal-digit (-R) detection is built when RR_OTFC_CHK_EN is defined.
module rr_otfc #(
  parameter int RADIX = 4,
  parameter int WIDTH = 4,
  localparam int R_BITS = $clog2(RADIX),
  localparam int D = R_BITS + 1,
  localparam int K = WIDTH * R_BITS + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [D-1:0] d_in,
  input  logic         d_valid,
  output logic         d_ready,
  output logic [K-1:0] p,
  output logic         p_valid,
  input  logic         p_ready,
  output logic         err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CW-1:0]     cnt_r;
  logic [K-1:0]      q_r;
  logic [K-1:0]      qm_r;
  logic [K-1:0]      p_r;
  logic              p_valid_r;

  logic              first_s;
  logic              last_s;
  logic              take_s;
  logic              complete_s;
  logic [D-1:0]      dig_s;
  logic              pos_s;
  logic              neg_s;
  logic [R_BITS-1:0] app_q_s;
  logic [R_BITS-1:0] app_qm_s;
  logic [K-1:0]      base_q_s;
  logic [K-1:0]      base_qm_s;
  logic [K-1:0]      q_src_s;
  logic [K-1:0]      qm_src_s;
  logic [K-1:0]      q_next_s;
  logic [K-1:0]      qm_next_s;

  assign first_s    = (cnt_r == '0);
  assign last_s     = (cnt_r == CW'(WIDTH - 1));
  assign d_ready    = !(last_s && p_valid_r && !p_ready);
  assign take_s     = d_valid && d_ready;
  assign complete_s = take_s && last_s;
  assign p          = p_r;
  assign p_valid    = p_valid_r;

`ifdef RR_OTFC_CHK_EN
  logic illegal_s;
  logic flag_r;
  logic flag_next_s;
  logic err_r;

  // Detect the -R encoding and substitute -(R-1) for it
  always_comb begin
    illegal_s = (d_in == {1'b1, {R_BITS{1'b0}}});
    if (illegal_s) begin
      dig_s = {1'b1, {(R_BITS - 1){1'b0}}, 1'b1};
    end else begin
      dig_s = d_in;
    end
  end

  // Sticky per-operand flag, restarted by the first digit of each operand
  always_comb begin
    if (first_s) begin
      flag_next_s = illegal_s;
    end else begin
      flag_next_s = flag_r | illegal_s;
    end
  end

  // Flag register and its copy published alongside p
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      if (take_s) begin
        flag_r <= flag_next_s;
      end
      if (complete_s) begin
        err_r <= flag_next_s;
      end
    end
  end

  assign err = err_r;
`else
  assign dig_s = d_in;
  assign err   = 1'b0;
`endif

  // Both appended fields are the low r bits of q and q-1 in every digit case
  always_comb begin
    pos_s    = !dig_s[D-1] && (dig_s != '0);
    neg_s    = dig_s[D-1];
    app_q_s  = dig_s[R_BITS-1:0];
    app_qm_s = dig_s[R_BITS-1:0] - R_BITS'(1);
    if (first_s) begin
      base_q_s  = '0;
      base_qm_s = '1;
    end else begin
      base_q_s  = q_r;
      base_qm_s = qm_r;
    end
    if (neg_s) begin
      q_src_s = base_qm_s;
    end else begin
      q_src_s = base_q_s;
    end
    if (pos_s) begin
      qm_src_s = base_q_s;
    end else begin
      qm_src_s = base_qm_s;
    end
    q_next_s  = (q_src_s << R_BITS)  | {{(K - R_BITS){1'b0}}, app_q_s};
    qm_next_s = (qm_src_s << R_BITS) | {{(K - R_BITS){1'b0}}, app_qm_s};
  end

  // Conversion registers and operand digit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
      q_r   <= '0;
      qm_r  <= '0;
    end else if (take_s) begin
      q_r  <= q_next_s;
      qm_r <= qm_next_s;
      if (last_s) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  // One-entry result buffer; a completing digit overwrites a draining result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_r       <= '0;
      p_valid_r <= 1'b0;
    end else if (complete_s) begin
      p_r       <= q_next_s;
      p_valid_r <= 1'b1;
    end else if (p_valid_r && p_ready) begin
      p_valid_r <= 1'b0;
    end
  end

endmodule
